// File: rtl/csam_pkg.sv
// Shared widths and saturation helpers for the carry-save multiply-accumulate datapath.
`default_nettype none

package csam_pkg;

   localparam int A_W   = 16;
   localparam int B_W   = 12;
   localparam int P_W   = 28;
   localparam int CNT_W = 16;

   // Returns {above_max, below_min} for a signed value against an out_w-bit signed range.
   function automatic logic [1:0] sat_flags(input logic signed [63:0] v, input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      return {(v > hi), (v < lo)};
   endfunction

   function automatic logic [CNT_W-1:0] sat16_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/csam_multiplier.sv
// Combinational 16x12 signed carry-save array multiplier producing a 28-bit product.
`default_nettype none

module csam_multiplier
   import csam_pkg::*;
(
   input  logic [A_W-1:0] a_i,
   input  logic [B_W-1:0] b_i,
   output logic [P_W-1:0] p_o
);

   logic [P_W-1:0] a_ext;
   logic [P_W-1:0] pp;
   logic [P_W-1:0] sum_v;
   logic [P_W-1:0] car_v;
   logic [P_W-1:0] maj_v;

   // The multiplier MSB has negative weight: its row is inverted and the +1 enters the final adder.
   always_comb begin
      a_ext = {{(P_W-A_W){a_i[A_W-1]}}, a_i};
      sum_v = '0;
      car_v = '0;
      pp    = '0;
      maj_v = '0;
      for (int i = 0; i < B_W; i++) begin
         pp = '0;
         if (b_i[i]) begin
            pp = (i == B_W - 1) ? ~(a_ext << i) : (a_ext << i);
         end
         maj_v = (sum_v & car_v) | (sum_v & pp) | (car_v & pp);
         sum_v = sum_v ^ car_v ^ pp;
         car_v = maj_v << 1;
      end
      p_o = sum_v + car_v + {{(P_W-1){1'b0}}, b_i[B_W-1]};
   end

endmodule

`default_nettype wire

// File: rtl/csam_mac_accumulator.sv
// Signed multiply-accumulate stage: one operand register stage feeding the CSA multiplier,
// a wide group accumulator and a saturated, handshaked result register.
`default_nettype none

module csam_mac_accumulator
   import csam_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_terms,
   output logic             out_sat
);

   localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic [A_W-1:0]   s1_a_q,      s1_a_d;
   logic [B_W-1:0]   s1_b_q,      s1_b_d;
   logic             s1_last_q,   s1_last_d;
   logic             s1_valid_q,  s1_valid_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_sum_q,   out_sum_d;
   logic [CNT_W-1:0] out_terms_q, out_terms_d;
   logic             out_sat_q,   out_sat_d;

   logic [P_W-1:0]   prod;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_sum;
   logic [63:0]      acc_sum_ext;
   logic [1:0]       clip;
   logic             advance;
   logic             accept;

   csam_multiplier u_mult (
      .a_i (s1_a_q),
      .b_i (s1_b_q),
      .p_o (prod)
   );

   // Only a last beat can be blocked, and only by an unconsumed result.
   assign advance  = s1_valid_q & (~s1_last_q | ~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | advance;
   assign accept   = in_valid & in_ready;

   assign prod_ext    = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
   assign acc_sum     = acc_q + prod_ext;
   assign acc_sum_ext = {{(64-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
   assign clip        = sat_flags(acc_sum_ext, OUT_W);

   always_comb begin
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_last_d   = s1_last_q;
      s1_valid_d  = s1_valid_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_terms_d = out_terms_q;
      out_sat_d   = out_sat_q;

      if (accept) begin
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_last_d  = in_last;
         s1_valid_d = 1'b1;
      end else if (advance) begin
         s1_valid_d = 1'b0;
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (advance) begin
         if (!s1_last_q) begin
            acc_d = acc_sum;
            cnt_d = sat16_inc(cnt_q);
         end else begin
            out_sum_d   = clip[1] ? SAT_MAX : (clip[0] ? SAT_MIN : acc_sum[OUT_W-1:0]);
            out_terms_d = sat16_inc(cnt_q);
            out_sat_d   = |clip;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_last_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_terms_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_last_q   <= s1_last_d;
         s1_valid_q  <= s1_valid_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_terms_q <= out_terms_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_terms = out_terms_q;
   assign out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_csam_mac_accumulator.sv
// Directed bench for csam_mac_accumulator with hand-computed expected results.
`default_nettype none

module tb_csam_mac_accumulator;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [11:0] in_b;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic [15:0] out_terms;
   logic        out_sat;

   int tests = 0;
   int fails = 0;

   csam_mac_accumulator #(.ACC_W(40), .OUT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_terms (out_terms),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a beat and returns one time unit after the edge that accepted it.
   task automatic send(input logic [15:0] a, input logic [11:0] b, input logic l);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = l;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_ready", {63'd0, in_ready}, 64'd1);
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk("wait_out_valid", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] s, input logic [15:0] t, input logic sat);
      chk({tag, "_sum"},   {32'd0, out_sum},   {32'd0, s});
      chk({tag, "_terms"}, {48'd0, out_terms}, {48'd0, t});
      chk({tag, "_sat"},   {63'd0, out_sat},   {63'd0, sat});
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk_out("rst", 32'd0, 16'd0, 1'b0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Single-term group: 3 * -2
      send(16'h0003, 12'hFFE, 1'b1);
      idle();
      chk("single_not_yet", {63'd0, out_valid}, 64'd0);
      tick();
      chk("single_valid", {63'd0, out_valid}, 64'd1);
      chk_out("single", 32'hFFFF_FFFA, 16'd1, 1'b0);
      tick();
      chk("single_consumed", {63'd0, out_valid}, 64'd0);

      // Four-term group with extreme operands
      send(16'h7FFF, 12'h7FF, 1'b0);
      send(16'h8000, 12'h7FF, 1'b0);
      send(16'h8000, 12'h800, 1'b0);
      send(16'h0001, 12'h001, 1'b1);
      idle();
      wait_out();
      chk_out("four", 32'd67106818, 16'd4, 1'b0);
      tick();

      // Positive then negative saturation
      for (int i = 0; i < 33; i++) send(16'h7FFF, 12'h7FF, (i == 32));
      idle();
      wait_out();
      chk_out("sat_pos", 32'h7FFF_FFFF, 16'd33, 1'b1);
      tick();
      for (int i = 0; i < 33; i++) send(16'h8000, 12'h7FF, (i == 32));
      idle();
      wait_out();
      chk_out("sat_neg", 32'h8000_0000, 16'd33, 1'b1);
      tick();

      // Backpressure: result A held while group B arrives
      out_ready = 1'b0;
      send(16'd1, 12'd1, 1'b1);
      idle();
      wait_out();
      chk_out("bp_a", 32'd1, 16'd1, 1'b0);
      send(16'd2, 12'd2, 1'b0);
      send(16'd3, 12'd3, 1'b0);
      send(16'd4, 12'd4, 1'b1);
      in_valid = 1'b1;
      in_a     = 16'd5;
      in_b     = 12'd5;
      in_last  = 1'b1;
      chk("bp_stall_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk("bp_stall_ready2", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_sum", {32'd0, out_sum}, 64'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
      tick();
      idle();
      chk("bp_b_valid", {63'd0, out_valid}, 64'd1);
      chk_out("bp_b", 32'd29, 16'd3, 1'b0);
      tick();
      chk("bp_c_valid", {63'd0, out_valid}, 64'd1);
      chk_out("bp_c", 32'd25, 16'd1, 1'b0);
      tick();
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Back-to-back groups of length 1, 2, 1 with continuous valid
      in_valid = 1'b1;
      in_a = 16'd2;      in_b = 12'd5; in_last = 1'b1;
      tick();
      in_a = 16'd1;      in_b = 12'd1; in_last = 1'b0;
      chk("b2b_ready1", {63'd0, in_ready}, 64'd1);
      tick();
      chk("b2b_g1_valid", {63'd0, out_valid}, 64'd1);
      chk_out("b2b_g1", 32'd10, 16'd1, 1'b0);
      in_a = 16'd3;      in_b = 12'd4; in_last = 1'b1;
      tick();
      chk("b2b_gap", {63'd0, out_valid}, 64'd0);
      in_a = 16'hFFFF;   in_b = 12'd7; in_last = 1'b1;
      chk("b2b_ready2", {63'd0, in_ready}, 64'd1);
      tick();
      idle();
      chk("b2b_g2_valid", {63'd0, out_valid}, 64'd1);
      chk_out("b2b_g2", 32'd13, 16'd2, 1'b0);
      tick();
      chk("b2b_g3_valid", {63'd0, out_valid}, 64'd1);
      chk_out("b2b_g3", 32'hFFFF_FFF9, 16'd1, 1'b0);
      tick();

      // Reset in the middle of a group
      for (int i = 0; i < 3; i++) send(16'd1, 12'd1, 1'b0);
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk_out("mid_rst", 32'd0, 16'd0, 1'b0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      send(16'd2, 12'd3, 1'b1);
      idle();
      wait_out();
      chk_out("post_rst", 32'd6, 16'd1, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
